// File: rtl/sram_req_ctrl.sv
// Request/response bridge to a single-port synchronous SRAM macro: issues one
// access per fire, captures DO a cycle later and returns in-order responses.
module sram_req_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 2,
  parameter int READ_ONLY  = 0
) (
  input  logic                    CK,
  input  logic                    RST,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH+1:0]   req_addr,
  input  logic                    req_write,
  input  logic [DATA_WIDTH/8-1:0] req_byte,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_write,
  output logic                    rsp_err,
  output logic                    CS,
  output logic [ADDR_WIDTH-1:0]   A,
  output logic                    WE,
  output logic [DATA_WIDTH/8-1:0] BYTE,
  output logic [DATA_WIDTH-1:0]   DI,
  input  logic [DATA_WIDTH-1:0]   DO
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(RSP_DEPTH - 1);
  localparam logic          RO      = (READ_ONLY != 0);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  wr;
    logic                  err;
  } rsp_t;

  rsp_t          fifo_q [RSP_DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          infl_q, infl_wr_q, infl_err_q;

  logic          fire, pop, push, ro_wr;
  logic [CW:0]   occ;
  rsp_t          push_ent, head;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

  // Counting the in-flight access reserves its buffer slot one cycle early,
  // which is what keeps the FIFO from ever overflowing.
  assign occ       = {1'b0, cnt_q} + {{CW{1'b0}}, infl_q};
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign req_ready = ~RST & ((occ < DEPTH_C) | pop);
  assign fire      = req_valid & req_ready;
  assign ro_wr     = RO & req_write;

  assign CS   = fire & ~ro_wr;
  assign WE   = fire & req_write & ~RO;
  assign A    = req_addr[ADDR_WIDTH+1:2];
  assign BYTE = req_byte;
  assign DI   = req_wdata;

  assign push           = infl_q;
  assign push_ent.rdata = infl_wr_q ? '0 : DO;
  assign push_ent.wr    = infl_wr_q;
  assign push_ent.err   = infl_err_q;

  assign head      = fifo_q[rp_q];
  assign rsp_rdata = rsp_valid ? head.rdata : '0;
  assign rsp_write = rsp_valid & head.wr;
  assign rsp_err   = rsp_valid & head.err;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) wp_d = (wp_q == LAST_P) ? '0 : wp_q + PW'(1);
    if (pop)  rp_d = (rp_q == LAST_P) ? '0 : rp_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      infl_q     <= 1'b0;
      infl_wr_q  <= 1'b0;
      infl_err_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      infl_q     <= fire;
      infl_wr_q  <= req_write;
      infl_err_q <= ro_wr;
      if (push) fifo_q[wp_q] <= push_ent;
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: a writable and a read-only instance share one
// stimulus stream; a response-queue model with its own memory image predicts both.
module tb_sram_req_ctrl;

  localparam int DEPTH = 2;

  logic        CK, RST, req_valid, req_write, rsp_ready;
  logic [12:0] req_addr;
  logic [3:0]  req_byte;
  logic [31:0] req_wdata;

  logic [1:0]  req_ready_w, rsp_valid_w, rsp_write_w, rsp_err_w, cs_w, we_w;
  logic [31:0] rdata_w [2];
  logic [10:0] a_w     [2];
  logic [3:0]  byte_w  [2];
  logic [31:0] di_w    [2];
  logic [31:0] do_w    [2];

  sram_req_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .RSP_DEPTH(DEPTH), .READ_ONLY(0)) dut0 (
    .CK(CK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready_w[0]),
    .req_addr(req_addr), .req_write(req_write), .req_byte(req_byte), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready), .rsp_rdata(rdata_w[0]),
    .rsp_write(rsp_write_w[0]), .rsp_err(rsp_err_w[0]),
    .CS(cs_w[0]), .A(a_w[0]), .WE(we_w[0]), .BYTE(byte_w[0]), .DI(di_w[0]), .DO(do_w[0]));

  sram_req_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .RSP_DEPTH(DEPTH), .READ_ONLY(1)) dut1 (
    .CK(CK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready_w[1]),
    .req_addr(req_addr), .req_write(req_write), .req_byte(req_byte), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready), .rsp_rdata(rdata_w[1]),
    .rsp_write(rsp_write_w[1]), .rsp_err(rsp_err_w[1]),
    .CS(cs_w[1]), .A(a_w[1]), .WE(we_w[1]), .BYTE(byte_w[1]), .DI(di_w[1]), .DO(do_w[1]));

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        wr;
    logic        err;
    int          avail;
  } ent_t;

  ent_t        q [2][$];
  logic [31:0] mac     [2][2048];
  logic [31:0] ref_mem [2][2048];
  int cyc = 0;
  int fire_cnt = 0;
  int fired_last = 0;
  int total = 0;
  int bad = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic exp_valid(input int i);
    return (q[i].size() > 0) && (q[i][0].avail <= cyc);
  endfunction

  function automatic logic exp_ready(input int i);
    return !RST && ((q[i].size() < DEPTH) || (exp_valid(i) && rsp_ready));
  endfunction

  // Macro model plus response model; responses appear two edges after the fire edge.
  always @(posedge CK) begin
    logic fv [2];
    logic pv [2];
    ent_t e;
    logic [31:0] m;
    if (cyc == 0) begin
      for (int i = 0; i < 2; i++) begin
        for (int w = 0; w < 2048; w++) begin
          mac[i][w]     <= (w >= 'h40 && w < 'h60) ? 32'h1000_0000 + w * 32'h111 : 32'h0;
          ref_mem[i][w] <= (w >= 'h40 && w < 'h60) ? 32'h1000_0000 + w * 32'h111 : 32'h0;
        end
        mac[i][5] <= 32'hDEADBEEF;  ref_mem[i][5] <= 32'hDEADBEEF;
        mac[i][8] <= 32'hAABBCCDD;  ref_mem[i][8] <= 32'hAABBCCDD;
        mac[i][2] <= 32'h0BADC0DE;  ref_mem[i][2] <= 32'h0BADC0DE;
      end
    end
    for (int i = 0; i < 2; i++) begin
      fv[i] = req_valid && exp_ready(i);
      pv[i] = exp_valid(i) && rsp_ready;
      if (cs_w[i]) begin
        if (we_w[i]) begin
          m = merge(mac[i][a_w[i]], byte_w[i], di_w[i]);
          mac[i][a_w[i]] <= m;
        end
        do_w[i] <= mac[i][a_w[i]];
      end
    end
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (RST) q[i].delete();
      else begin
        if (pv[i]) void'(q[i].pop_front());
        if (fv[i]) begin
          e.wr    = req_write;
          e.err   = (i == 1) && req_write;
          e.avail = cyc + 1;
          if (req_write) begin
            e.rdata = 32'h0;
            if (i == 0) ref_mem[i][req_addr[12:2]] <= merge(ref_mem[i][req_addr[12:2]], req_byte, req_wdata);
          end else e.rdata = ref_mem[i][req_addr[12:2]];
          q[i].push_back(e);
        end
      end
    end
    fired_last = fv[0] ? 1 : 0;
    if (fv[0]) fire_cnt = fire_cnt + 1;
  end

  always @(negedge CK) begin
    if (cyc >= 1) begin
      for (int i = 0; i < 2; i++) begin
        logic f;
        f = req_valid && exp_ready(i);
        chk($sformatf("req_ready[%0d]", i), 32'(req_ready_w[i]), 32'(exp_ready(i)));
        chk($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid_w[i]), 32'(exp_valid(i)));
        if (exp_valid(i)) begin
          chk($sformatf("rsp_rdata[%0d]", i), rdata_w[i], q[i][0].rdata);
          chk($sformatf("rsp_write[%0d]", i), 32'(rsp_write_w[i]), 32'(q[i][0].wr));
          chk($sformatf("rsp_err[%0d]", i), 32'(rsp_err_w[i]), 32'(q[i][0].err));
        end
        chk($sformatf("CS[%0d]", i), 32'(cs_w[i]), 32'(f && !(i == 1 && req_write)));
        chk($sformatf("WE[%0d]", i), 32'(we_w[i]), 32'(f && req_write && i == 0));
        chk($sformatf("A[%0d]", i), 32'(a_w[i]), 32'(req_addr[12:2]));
        chk($sformatf("BYTE[%0d]", i), 32'(byte_w[i]), 32'(req_byte));
        chk($sformatf("DI[%0d]", i), di_w[i], req_wdata);
      end
      chk("fifo_bound0", 32'(dut0.cnt_q <= DEPTH), 32'd1);
      chk("fifo_bound1", 32'(dut1.cnt_q <= DEPTH), 32'd1);
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic single_read();
    tick();
    req_valid = 1'b1; req_addr = 13'h0014; req_write = 1'b0; rsp_ready = 1'b1;
    @(negedge CK);
    chk("rd_CS", 32'(cs_w[0]), 32'd1);
    chk("rd_A", 32'(a_w[0]), 32'h005);
    chk("rd_WE", 32'(we_w[0]), 32'd0);
    tick();
    req_valid = 1'b0;
    tick();
    @(negedge CK);
    chk("rd_rsp_valid", 32'(rsp_valid_w[0]), 32'd1);
    chk("rd_rdata0", rdata_w[0], 32'hDEADBEEF);
    chk("rd_rdata1", rdata_w[1], 32'hDEADBEEF);
    chk("rd_err", 32'(rsp_err_w[0]), 32'd0);
  endtask

  task automatic wr_rd(input logic [12:0] ad, input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] exp0, input logic [31:0] exp1);
    tick();
    req_valid = 1'b1; req_addr = ad; req_write = 1'b1; req_byte = be; req_wdata = wd;
    @(negedge CK);
    chk("wr_WE0", 32'(we_w[0]), 32'd1);
    chk("wr_BYTE0", 32'(byte_w[0]), 32'(be));
    chk("wr_CS1", 32'(cs_w[1]), 32'd0);
    chk("wr_WE1", 32'(we_w[1]), 32'd0);
    tick();
    req_write = 1'b0; req_byte = 4'hF;
    tick();
    req_valid = 1'b0;
    @(negedge CK);
    chk("ro_wr_err", 32'(rsp_err_w[1]), 32'd1);
    chk("ro_wr_write", 32'(rsp_write_w[1]), 32'd1);
    chk("ro_wr_rdata", rdata_w[1], 32'h0);
    chk("wr_err0", 32'(rsp_err_w[0]), 32'd0);
    tick();
    @(negedge CK);
    chk("rb_rdata0", rdata_w[0], exp0);
    chk("rb_rdata1", rdata_w[1], exp1);
  endtask

  initial begin
    int base, idx;
    RST = 1'b1; req_valid = 1'b1; req_addr = 13'h0014; req_write = 1'b0;
    req_byte = 4'hF; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge CK);
      chk("rst_CS", 32'(cs_w[0]), 32'd0);
      chk("rst_WE", 32'(we_w[0]), 32'd0);
      chk("rst_ready", 32'(req_ready_w[0]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_w[0]), 32'd0);
      chk("rst_rdata", rdata_w[0], 32'h0);
    end
    tick();
    RST = 1'b0; req_valid = 1'b0;
    @(negedge CK);
    chk("ready_after_rst", 32'(req_ready_w[0]), 32'd1);

    single_read();
    wr_rd(13'h0020, 4'b0101, 32'h11223344, 32'hAA22CC44, 32'hAABBCCDD);
    wr_rd(13'h0008, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0BADC0DE);

    // streaming: one fire per cycle with the consumer always ready
    tick();
    base = fire_cnt;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_addr = 13'h0100 + 13'(i * 4); rsp_ready = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    chk("stream_fires", 32'(fire_cnt - base), 32'd16);
    repeat (3) tick();

    // backpressure: stall, then resume with advancing addresses
    base = fire_cnt;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 6) begin
        @(negedge CK);
        chk("bp_stall_fires", 32'(fire_cnt - base), 32'(DEPTH));
        chk("bp_ready_low", 32'(req_ready_w[0]), 32'd0);
        #1;
      end
      req_valid = 1'b1; req_addr = 13'h0140 + 13'(idx * 4); rsp_ready = (c >= 6);
      tick();
      if (fired_last != 0) idx++;
    end
    req_valid = 1'b0;
    chk("bp_total_fires", 32'(fire_cnt - base), 32'd8);
    repeat (4) tick();

    // reset with two responses pending
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 13'h0104;
    repeat (3) tick();
    req_valid = 1'b0;
    @(negedge CK);
    chk("pending_before_rst", 32'(rsp_valid_w[0]), 32'd1);
    tick();
    RST = 1'b1; rsp_ready = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CK);
    chk("dropped0", 32'(rsp_valid_w[0]), 32'd0);
    chk("dropped1", 32'(rsp_valid_w[1]), 32'd0);
    single_read();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
Initiator-side controller for the 32-bit x 2048-word synchronous memory macro port (CK/CS/A/WE/BYTE/DI/DO, one-cycle registered read data). It converts a core-side valid/ready request stream into macro accesses and returns in-order responses through a valid/ready response stream. A small response buffer lets the bridge sustain one access per cycle under response backpressure. It sits between the boot-ROM/SRAM bus slave and the memory macro.

Parameters:
ADDR_WIDTH, 11, word-address width driven on A; the byte address is ADDR_WIDTH+2 bits.
DATA_WIDTH, 32, data width; BYTE width is DATA_WIDTH/8.
RSP_DEPTH, 2, response buffer entries; must be >= 2.
READ_ONLY, 0, 1 = writes are never issued to the macro and are answered with an error.

Ports:
CK  in  1  clock; all logic on posedge
RST  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready (fire)
req_addr  in  ADDR_WIDTH+2  byte address; bits [1:0] ignored
req_write  in  1  1 = write, 0 = read
req_byte  in  4  write byte enables
req_wdata  in  32  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready (pop)
rsp_rdata  out  32  read data; 0 for write responses
rsp_write  out  1  echoes req_write of the request
rsp_err  out  1  1 = write rejected (READ_ONLY=1 only)
CS  out  1  macro chip select
A  out  ADDR_WIDTH  macro word address
WE  out  1  macro write enable
BYTE  out  4  macro byte enables
DI  out  32  macro write data
DO  in  32  macro read data, valid in the cycle after CS

Behaviour:
- Reset (RST high at posedge): buffer emptied, in-flight flag cleared. rsp_valid=0, rsp_err=0, rsp_write=0, rsp_rdata=0. req_ready=0 while RST is high. CS=0 and WE=0 while RST is high. DO returning from an access issued before reset is discarded.
- Issue is combinational in the fire cycle: CS=fire. WE=fire & req_write & ~READ_ONLY. A=req_addr[ADDR_WIDTH+1:2]. BYTE=req_byte. DI=req_wdata. When CS=0, A, BYTE and DI pass through unchanged and WE=0.
- READ_ONLY=1 and a write fires: CS=0 and WE=0, so there is no macro access. A response with rsp_err=1, rsp_write=1 and rdata=0 is still produced, in order.
- In-flight stage: a registered flag plus write/err bits, set on fire. In the next cycle the entry is pushed into the response FIFO. For reads the pushed rdata is DO sampled in that cycle. Every fire yields exactly one push, one cycle later.
- Latency: fire at cycle t produces rsp_valid at cycle t+2 at the earliest, provided the FIFO was empty.
- Occupancy = FIFO count + in-flight flag. req_ready = ~RST & ((occupancy < RSP_DEPTH) | pop). This is a documented combinational path from rsp_ready to req_ready.
- FIFO: circular, RSP_DEPTH entries, in-order, rsp_* driven from the head entry. A push and a pop in the same cycle are both performed. The FIFO never overflows, which the occupancy rule guarantees; this is an assertion in the bench.
- Throughput: with rsp_ready held 1 and req_valid held 1, one fire per cycle sustained indefinitely.
- rsp_* is stable while rsp_valid=1 and rsp_ready=0.
- Back-to-back write then read to the same address: the read returns the new data. The macro write completes at the fire edge.
- Partial writes (req_byte != 4'hF) are passed straight through; there is no read-modify-write.
- Reset asserted mid-stream: all pending responses are dropped. The first response after reset corresponds to the first request fired after reset.

Test Plan:
- Reset: RST=1 for 3 cycles with req_valid=1 -> CS=0, WE=0, req_ready=0, rsp_valid=0. Cycle after release: req_ready=1.
- Single read: preload word 0x005=0xDEADBEEF; read addr 0x0014 with rsp_ready=1 -> CS=1, A=0x005, WE=0 at t; rsp_valid=1, rsp_rdata=0xDEADBEEF, rsp_err=0 at t+2.
- Byte write then read: write addr 0x0020, byte=4'b0101, wdata=0x11223344 over old 0xAABBCCDD -> WE=1, BYTE=4'b0101. Following read returns 0xAA22CC44.
- Streaming: 16 reads to consecutive addresses with rsp_ready=1 -> 16 fires in 16 cycles; responses are in order with correct data.
- Backpressure: rsp_ready=0, req_valid=1 -> exactly RSP_DEPTH fires, then req_ready=0 and rsp_* held stable. Raising rsp_ready resumes with no loss and no duplication.
- READ_ONLY=1: write to 0x0008 -> CS=0, WE=0, response has rsp_err=1, rsp_write=1. Memory is unchanged on readback. Also check reset asserted with 2 responses pending -> both dropped.
